// File: rtl/vram_arbiter_if.sv
// CPU request/ack bus plus the single-port framebuffer memory bus shared by the arbiter.
// The master side is the environment (CPU requester and RAM); the slave side is the arbiter.
interface vram_arbiter_if #(
  parameter int AW = 15,
  parameter int DW = 12
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Shares a synchronous-read VRAM between fixed display fetch slots and a CPU req/ack port.
// Pixel data and syncs leave two cycles behind the timing inputs.
module vram_arbiter #(
  parameter int HRES  = 640,
  parameter int VRES  = 480,
  parameter int SHIFT = 2,
  parameter int AW    = 15,
  parameter int DW    = 12
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          display_en,
  input  logic [9:0]    vga_x,
  input  logic [8:0]    vga_y,
  input  logic          hs_in,
  input  logic          vs_in,
  vram_arbiter_if.slave bus,
  output logic [DW-1:0] pix_rgb,
  output logic          hs_out,
  output logic          vs_out
);
  localparam int          FB_W  = HRES >> SHIFT;
  localparam int          FB_H  = VRES >> SHIFT;
  localparam int unsigned DEPTH = FB_W * FB_H;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, ACK} state_t;

  state_t        state;
  logic [AW-1:0] cap_addr;
  logic          cap_we;
  logic [DW-1:0] cap_wdata;
  logic          slot;
  logic          slot_d1;
  logic          en_d1;
  logic          hs_d1;
  logic          vs_d1;
  logic [DW-1:0] latch;
  logic          in_range;
  logic [AW-1:0] pix_addr;

  assign slot     = display_en && (vga_x[SHIFT-1:0] == '0);
  assign pix_addr = AW'(AW'(vga_y >> SHIFT) * AW'(FB_W) + AW'(vga_x >> SHIFT));
  assign in_range = (32'(cap_addr) < DEPTH);

  // A display slot always owns the port; the CPU only drives it while in ISSUE.
  always_comb begin
    bus.mem_addr  = cap_addr;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = cap_wdata;
    if (slot) begin
      bus.mem_addr = pix_addr;
    end else if (state == ISSUE) begin
      bus.mem_we = cap_we && in_range;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.cpu_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
      cap_addr      <= '0;
      cap_we        <= 1'b0;
      cap_wdata     <= '0;
    end else begin
      bus.cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            cap_addr  <= bus.cpu_addr;
            cap_we    <= bus.cpu_we;
            cap_wdata <= bus.cpu_wdata;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!slot) begin
            if (cap_we) begin
              state       <= ACK;
              bus.cpu_ack <= 1'b1;
            end else begin
              state <= WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          bus.cpu_rdata <= in_range ? bus.mem_rdata : '0;
          bus.cpu_ack   <= 1'b1;
          state         <= ACK;
        end
        ACK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // pix_rgb is the second delay stage, so it is fed from the value the latch is about to take.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      slot_d1 <= 1'b0;
      en_d1   <= 1'b0;
      hs_d1   <= 1'b0;
      vs_d1   <= 1'b0;
      hs_out  <= 1'b0;
      vs_out  <= 1'b0;
      latch   <= '0;
      pix_rgb <= '0;
    end else begin
      slot_d1 <= slot;
      en_d1   <= display_en;
      hs_d1   <= hs_in;
      vs_d1   <= vs_in;
      hs_out  <= hs_d1;
      vs_out  <= vs_d1;
      if (slot_d1) begin
        latch <= bus.mem_rdata;
      end
      pix_rgb <= en_d1 ? (slot_d1 ? bus.mem_rdata : latch) : '0;
    end
  end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares one single-port, synchronous-read video RAM between the VGA scan-out path and a CPU-side requester. It sits between the display timing generator (display_en/vga_x/vga_y/hs/vs) and the framebuffer memory. Display fetches get fixed, guaranteed slots. CPU reads and writes use every other cycle through a req/ack handshake. Pixel data and syncs leave the block aligned, two cycles behind the timing inputs.

## Interface
- HRES, 640: active horizontal pixels of the timing generator
- VRES, 480: active vertical lines
- SHIFT, 2: pixel-to-framebuffer downscale (log2); framebuffer is (HRES>>SHIFT) x (VRES>>SHIFT); SHIFT >= 1
- AW, 15: memory address width; must hold DEPTH = (HRES>>SHIFT)*(VRES>>SHIFT) (19200 at defaults)
- DW, 12: pixel/data width (RGB444)

Ports:
- pclk  in  1  pixel clock, the only clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- display_en  in  1  active-video flag from timing generator
- vga_x  in  10  current column (0..HRES-1 while active)
- vga_y  in  9  current row (0..VRES-1 while active)
- hs_in, vs_in  in  1 each  syncs from timing generator
- cpu_req  in  1  request; held high until cpu_ack seen
- cpu_we  in  1  1 = write, 0 = read; sampled with request
- cpu_addr  in  AW  word address
- cpu_wdata  in  DW  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DW  read data, valid while cpu_ack=1 and held until the next read completes
- mem_addr  out  AW  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid one cycle after address
- pix_rgb  out  DW  pixel to DAC, 0 when blanked
- hs_out, vs_out  out  1 each  syncs delayed to align with pix_rgb

## Operation
- Display slot: slot = display_en && (vga_x[SHIFT-1:0] == 0). Pixel address = (vga_y>>SHIFT)*(HRES>>SHIFT) + (vga_x>>SHIFT), truncated to AW. In a slot cycle, mem_addr = pixel address and mem_we = 0, unconditionally.
- Pixel path: slot_d1 <= slot. When slot_d1 = 1, a pixel latch captures mem_rdata. The latch holds between slots. en_d1 and en_d2 delay display_en. pix_rgb = en_d2 ? latch : 0, registered. hs and vs pass through the same 2-stage delay.
- CPU FSM states: IDLE, ISSUE, WAIT_RD, ACK.
  - IDLE: if cpu_req, capture addr, we and wdata into registers and go to ISSUE.
  - ISSUE: if slot, stay. Otherwise drive mem_addr = captured addr and mem_we = captured we && in_range, mem_wdata = captured data. Go to ACK for a write or WAIT_RD for a read.
  - WAIT_RD: cpu_rdata <= in_range ? mem_rdata : 0. Go to ACK. The port is free this cycle. Only a slot may use it; the CPU issues nothing.
  - ACK: cpu_ack = 1. Go to IDLE.
- in_range = captured addr < DEPTH. An out-of-range write is suppressed (mem_we stays 0) but still acked. An out-of-range read returns 0.
- A requester drops cpu_req in the cycle it sees cpu_ack. If cpu_req is still high in IDLE, that is a new request.
- In non-slot cycles with no CPU issue, mem_we = 0 and mem_addr = captured CPU address.
- mem_addr, mem_we and mem_wdata are combinational from registered state plus slot.

## Timing
- Reset (async, immediate): state IDLE, cpu_ack 0, cpu_rdata 0, latch 0, pix_rgb 0, hs_out 0, vs_out 0, all delay stages 0, mem_we 0. Reset mid-transaction aborts it: no ack, and an in-flight write enable drops immediately.
- Write with no slot collision: req sampled at edge 0, ISSUE during cycle 1 (mem_we high exactly 1 cycle), cpu_ack high in cycle 2.
- Read with no slot collision: ISSUE cycle 1, WAIT_RD cycle 2, cpu_ack and valid cpu_rdata in cycle 3.
- Each slot collision adds 1 cycle. At most 1 collision occurs, since slots are 2^SHIFT >= 2 cycles apart.
- pix_rgb, hs_out and vs_out lag display_en, hs_in and vs_in by exactly 2 cycles.
- Throughput: one CPU access per 3 cycles (write) or 4 cycles (read) at best.

## Test plan
- Reset: assert rst mid-stream → all outputs 0 immediately; after release, state IDLE with no spurious ack.
- Write in blanking: display_en=0, write addr 5 data 0xABC → mem_we=1 for 1 cycle with mem_addr=5 and mem_wdata=0xABC, cpu_ack 2 cycles after req sampled.
- Read back in blanking: read addr 5 → cpu_ack 3 cycles after req, cpu_rdata=0xABC.
- Slot collision: issue a write so that ISSUE coincides with vga_x=8 and display_en=1 → mem_we low in that cycle with mem_addr = pixel address; write lands the next cycle; ack delayed by 1.
- Scan-out: preload addr 161 = 0x0F0 and drive vga_y=4 with vga_x=4..7 active → pix_rgb=0x0F0 for 4 cycles starting 2 cycles after vga_x=4. With display_en=0, pix_rgb=0 two cycles later. hs_out and vs_out equal hs_in and vs_in delayed by 2.
- Range check: write addr 19200 → no mem_we, ack still issued. Read addr 19200 → cpu_rdata=0 with ack.
